// File: rtl/serial_compare_ctrl_if.sv
// Request/response bundle between a datapath and the serial comparator controller.
// The master drives the request and operands; the slave returns status and the relation vector.
interface serial_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [5:0]       Y;

    modport master (
        output start, A, B,
        input  busy, done, Y
    );

    modport slave (
        input  start, A, B,
        output busy, done, Y
    );
endinterface

// File: rtl/serial_compare_ctrl.sv
// MSB-first bit-serial unsigned comparator controller with start/busy/done handshake.
// One bit per clock through a shared 1-bit compare stage; stops at the first differing bit.
module serial_compare_bit (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic gt
);
    assign diff = a ^ b;
    assign gt   = a & ~b;
endmodule

module serial_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_compare_ctrl_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] Y_EQ = 6'b110001;
    localparam logic [5:0] Y_GT = 6'b101010;
    localparam logic [5:0] Y_LT = 6'b010110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [5:0]       y_q, y_d;
    logic             load;
    logic             bit_diff, bit_gt;

    serial_compare_bit u_bit (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .diff (bit_diff),
        .gt   (bit_gt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        y_d     = y_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    idx_d   = IW'(WIDTH - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // start is deliberately not looked at here: no queuing or restart mid-scan
                if (bit_diff) begin
                    y_d     = bit_gt ? Y_GT : Y_LT;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    y_d     = Y_EQ;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    idx_d   = IW'(WIDTH - 1);
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            if (load) begin
                a_q <= bus.A;
                b_q <= bus.B;
            end
        end
    end

    // done is a decode of the DONE state register, so it is registered and one cycle wide
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.Y    = y_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Table-driven and sequence tests for serial_compare_ctrl with an expected-result queue.
module tb_serial_compare_ctrl;
    localparam int W = 8;
    localparam logic [5:0] EQ = 6'b110001;
    localparam logic [5:0] GT = 6'b101010;
    localparam logic [5:0] LT = 6'b010110;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [5:0]   y;
        int           k;
    } vec_t;

    typedef struct {
        logic [5:0] y;
        int         k;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[8];

    serial_compare_ctrl_if #(.WIDTH(W)) bus ();

    serial_compare_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at the negedge right after the accepting edge; counts edges until done.
    task automatic wait_done(output int edges, output int busy_n, output bit got);
        edges  = 0;
        busy_n = bus.busy ? 1 : 0;
        got    = 1'b0;
        while (!got && edges < W + 4) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.done) got = 1'b1;
            else if (bus.busy) busy_n++;
        end
    endtask

    task automatic check_result(input string name, input int edges, input int busy_n, input bit got);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        if (!got) begin
            chk({name, "_timeout"}, 0, 1);
            return;
        end
        chk({name, "_y"}, int'(bus.Y), int'(e.y));
        chk({name, "_lat"}, edges, e.k);
        chk({name, "_busy"}, busy_n, e.k);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [5:0] y, input int k);
        int edges, busy_n;
        bit got;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1; bus.A = a; bus.B = b;
        e.y = y; e.k = k;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0; bus.A = W'($urandom); bus.B = W'($urandom);
        wait_done(edges, busy_n, got);
        check_result(name, edges, busy_n, got);
        @(negedge clk);
        chk({name, "_done_1cyc"}, int'(bus.done), 0);
        chk({name, "_idle_busy"}, int'(bus.busy), 0);
        chk({name, "_y_hold"}, int'(bus.Y), int'(y));
    endtask

    initial begin
        int edges, busy_n;
        bit got;
        exp_t e;

        vecs[0] = '{a: 8'hA5, b: 8'hA5, y: EQ, k: 8};
        vecs[1] = '{a: 8'h80, b: 8'h7F, y: GT, k: 1};
        vecs[2] = '{a: 8'h12, b: 8'h13, y: LT, k: 8};
        vecs[3] = '{a: 8'h00, b: 8'hFF, y: LT, k: 1};
        vecs[4] = '{a: 8'h3C, b: 8'h34, y: GT, k: 5};
        vecs[5] = '{a: 8'h40, b: 8'h60, y: LT, k: 3};
        vecs[6] = '{a: 8'h00, b: 8'h00, y: EQ, k: 8};
        vecs[7] = '{a: 8'h01, b: 8'h00, y: GT, k: 8};

        // reset held with start asserted: nothing may move
        rst_n = 1'b0; bus.start = 1'b1; bus.A = 8'h5A; bus.B = 8'hC3;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_y", int'(bus.Y), 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_busy", int'(bus.busy), 0);
        chk("rst_hold_done", int'(bus.done), 0);
        chk("rst_hold_y", int'(bus.Y), 0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", int'(bus.busy), 0);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].k);

        // start pulsed during RUN with new operands is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.A = 8'h80; bus.B = 8'h7F;
        e.y = GT; e.k = 1; sb.push_back(e);
        @(negedge clk);
        bus.A = 8'h00; bus.B = 8'hFF;
        wait_done(edges, busy_n, got);
        bus.start = 1'b0;
        check_result("midrun", edges, busy_n, got);
        @(negedge clk);
        chk("midrun_no_restart", int'(bus.busy), 0);
        chk("midrun_y_hold", int'(bus.Y), int'(GT));

        // start held through DONE: straight back into RUN
        @(negedge clk);
        bus.start = 1'b1; bus.A = 8'h12; bus.B = 8'h13;
        e.y = LT; e.k = 8; sb.push_back(e);
        @(negedge clk);
        bus.A = 8'hFF; bus.B = 8'h00;
        e.y = GT; e.k = 1; sb.push_back(e);
        wait_done(edges, busy_n, got);
        check_result("b2b_first", edges, busy_n, got);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_no_gap", int'(bus.busy), 1);
        chk("b2b_y_stable", int'(bus.Y), int'(LT));
        wait_done(edges, busy_n, got);
        check_result("b2b_second", edges, busy_n, got);
        @(negedge clk);
        chk("b2b_end_idle", int'(bus.busy), 0);

        // asynchronous reset at idx=4 of an equal scan aborts with no done
        @(negedge clk);
        bus.start = 1'b1; bus.A = 8'hA5; bus.B = 8'hA5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_y", int'(bus.Y), 0);
        got = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        chk("abort_no_done", int'(got), 0);
        rst_n = 1'b1;
        run_op("after_abort", 8'h3C, 8'h34, GT, 5);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_compare_ctrl.md
# serial_compare_ctrl

Sequencing controller that compares two WIDTH-bit unsigned operands with a single 1-bit comparison stage. It scans the operands MSB-first, one bit per clock, and stops at the first differing bit. It returns the team's 6-bit relation vector and signals completion with a start/busy/done handshake. It sits between a requesting datapath and the shared per-bit comparator, so operand width is a parameter and not a property of the comparator.

## Interface
- WIDTH, 8, operand width in bits; legal range is ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE or DONE.
- A  input  WIDTH  operand A (unsigned). Captured on the accepting edge.
- B  input  WIDTH  operand B (unsigned). Captured on the accepting edge.
- busy  output  1  high while the scan is in progress (RUN).
- done  output  1  one-cycle pulse marking a valid new Y.
- Y  output  6  relation vector: Y[0] eq, Y[1] neq, Y[2] lt, Y[3] gt, Y[4] le, Y[5] ge. All bits describe A relative to B.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: scanning, one bit per cycle.
  - DONE: result cycle.
- Accepting edge: a rising clk with start=1 while in IDLE or DONE.
  - Captures A and B into internal registers.
  - Loads the bit index with WIDTH-1.
  - Moves to RUN.
- RUN, each cycle: the per-bit stage compares the captured A[idx] against B[idx]. At the next edge:
  - If the bits differ: Y is loaded with the lt or gt result, then state moves to DONE.
  - Else if idx==0: Y is loaded with the eq result, then state moves to DONE.
  - Else: idx decrements and state stays in RUN.
- Result encodings:
  - eq: 6'b110001.
  - gt: 6'b101010.
  - lt: 6'b010110.
  - Exactly one of eq, lt and gt is set, and Y[1]=~Y[0], Y[4]=lt|eq, Y[5]=gt|eq.
- DONE lasts exactly one cycle. It exits to RUN if start=1 (back-to-back request), otherwise to IDLE.
- start while in RUN is ignored: no queuing, no restart, and the captured operands are unaffected.
- A and B may change freely after the accepting edge; only the captured copies are scanned.
- Y holds its last result from one DONE to the next, including through IDLE and RUN. It is never partially updated.
- The index counter needs ceil(log2(WIDTH)) bits. It never wraps: the transition to DONE at idx==0 precedes any decrement past 0.

## Timing
- Reset values, applied immediately on rst_n low and independent of clk:
  - Outputs: busy=0, done=0, Y=6'b000000.
  - Internal: state=IDLE, idx=0, operand registers=0.
- Reset during RUN or DONE aborts the operation. No done pulse is produced for it.
- First accepting edge after rst_n rises: the first rising edge with rst_n=1 and start=1.
- Latency, with k = number of bits examined (k = WIDTH-p when the first mismatch is at bit p, k = WIDTH when equal):
  - done and the new Y appear after the k-th edge following the accepting edge.
  - Best case: 1 cycle (MSB differs).
  - Worst case: WIDTH cycles (equal, or differing only at bit 0).
- busy=1 from the cycle after the accepting edge through the last RUN cycle. busy=0 during DONE.
- done is registered and high for exactly one cycle.
- With start held high continuously, operations repeat with no IDLE gap: one DONE cycle between RUN periods.
- Throughput: one comparison per k+1 cycles.

## Test plan
- Reset: hold rst_n=0 with start=1 and arbitrary A/B, and drop rst_n asynchronously between edges. Required: busy=0, done=0, Y=000000 immediately, and no state change while reset is asserted.
- Equal: WIDTH=8, A=B=8'hA5, one start pulse. Required: busy high for 8 cycles, done pulse after the 8th edge, Y=6'b110001.
- Early gt: A=8'h80, B=8'h7F. Required: done after the 1st edge, busy high for 1 cycle, Y=6'b101010.
- Late lt: A=8'h12, B=8'h13. Required: done after the 8th edge, Y=6'b010110.
- Handshake:
  - Pulse start mid-RUN with new operands A=8'h00, B=8'hFF. Required: ignored, and the original result (6'b101010 from operands A=8'h80, B=8'h7F) is reported.
  - Hold start high during DONE with A=8'hFF, B=8'h00. Required: RUN re-entered directly, next done after 1 edge with Y=6'b101010.
  - Y stays stable between done pulses.
- Reset mid-RUN: assert rst_n=0 at idx=4 of an equal-operand scan. Required: no done pulse, Y=000000. A new start after release completes normally.
